yutorina_bus_slave_mem: RTL and testbench
=========================================

YUTORINA_BUS_SLAVE_MEM -- requirements
Module: yutorina_bus_slave_mem

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, giving the number of wait cycles inserted before each acknowledge (legal range 0-15).
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 11, giving the log2 of the word depth (2048 words x 32 bits).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset; synchronous and active-high.
REQ-005 The block SHALL have port cs_, input, 1 bit, chip select, active low.
REQ-006 The block SHALL have port as_, input, 1 bit, address strobe, active low.
REQ-007 The block SHALL have port rw, input, 1 bit, access direction: 1 = READ, 0 = WRITE.
REQ-008 The block SHALL have port addr, input, DEPTH_LOG2 bits, word address.
REQ-009 The block SHALL have port wr_data, input, 32 bits, write data.
REQ-010 The block SHALL have port rd_data, output, 32 bits, read data, registered.
REQ-011 The block SHALL have port rdy_, output, 1 bit, ready/acknowledge, active low, registered.

Function
REQ-012 The block SHALL contain a three-state FSM with states IDLE, WAIT and ACK.
REQ-013 In IDLE, a request (cs_=0 and as_=0 at a rising edge) SHALL latch addr, rw and wr_data, load the wait counter with WAIT_CYCLES, and transition to WAIT, or directly to ACK when WAIT_CYCLES=0.
REQ-014 In WAIT, the counter SHALL decrement by 1 per cycle, and the FSM SHALL enter ACK on the edge where the counter reaches 1.
REQ-015 A request sampled at edge N SHALL produce rdy_=0 for exactly one cycle, starting after edge N+1+WAIT_CYCLES.
REQ-016 In ACK, reads SHALL drive rd_data with mem[latched addr], and the value SHALL be valid exactly while rdy_=0.
REQ-017 In ACK, writes SHALL update mem[latched addr] with the latched wr_data on the edge entering ACK, and rd_data SHALL be 0.
REQ-018 rd_data SHALL be 0 in every cycle in which rdy_=1.
REQ-019 ACK SHALL always return to IDLE after one cycle; a request still asserted in that IDLE cycle SHALL be treated as a new transaction (back-to-back, no dead cycle beyond IDLE).
REQ-020 Changes on addr, rw or wr_data during WAIT SHALL be ignored; the latched values SHALL be used.
REQ-021 If cs_ or as_ is deasserted in WAIT, the block SHALL abort to IDLE: no write performed, rdy_ stays 1.
REQ-022 Memory contents SHALL NOT be initialised or cleared by the block.

Reset
REQ-023 When rst=1 at a rising edge, the block SHALL set state=IDLE, rdy_=1, rd_data=0 and counter=0.
REQ-024 A reset during WAIT or ACK SHALL abandon the transaction; a pending write not yet committed SHALL NOT occur.
REQ-025 rst SHALL take priority over any request sampled at the same edge.

Configuration
REQ-026 With macro YUTORINA_SLAVE_WAIT_EN defined, the block SHALL include the wait counter and WAIT state, and WAIT_CYCLES SHALL apply as specified.
REQ-027 Without YUTORINA_SLAVE_WAIT_EN, the block SHALL omit the WAIT state and counter, ignore WAIT_CYCLES, and acknowledge every request at edge N+1, making WAIT-state aborts impossible.

Verification
REQ-028 The bench SHALL cover: reset, then write 0xDEADBEEF to addr 0x010 with WAIT_CYCLES=2 -> rdy_=0 one cycle after edge N+3; read of 0x010 then returns 0xDEADBEEF with rdy_=0.
REQ-029 The bench SHALL cover: WAIT_CYCLES=0, back-to-back reads of 0x000 and 0x7FF held continuously -> rdy_ low on alternating cycles; rd_data=0 between acknowledges.
REQ-030 The bench SHALL cover: write 0x12345678 to 0x020, with cs_ deasserted one cycle after the request (WAIT_CYCLES=3) -> no rdy_; a subsequent read of 0x020 returns the old value.
REQ-031 The bench SHALL cover: addr changed from 0x030 to 0x031 during WAIT on a read -> returns mem[0x030].
REQ-032 The bench SHALL cover: rst asserted in the ACK-pending WAIT cycle of a write -> rdy_=1 and rd_data=0 next cycle; target word unchanged.
REQ-033 The bench SHALL cover: build without YUTORINA_SLAVE_WAIT_EN, WAIT_CYCLES=5 -> rdy_=0 at edge N+1 for every access.

Source files
------------

// File: rtl/yutorina_bus_slave_mem.sv
// yutorina_bus_slave_mem: 2**DEPTH_LOG2 x 32 bus slave memory with an
// active-low chip-select / address-strobe handshake and a registered,
// single-cycle active-low acknowledge.
//
// Build option: define YUTORINA_SLAVE_WAIT_EN to insert WAIT_CYCLES wait
// cycles before each acknowledge. Without it every request is acknowledged
// one cycle after it is sampled and WAIT_CYCLES has no effect.
module yutorina_bus_slave_mem #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH_LOG2  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs_,
  input  logic                  as_,
  input  logic                  rw,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output logic                  rdy_
);

`ifdef YUTORINA_SLAVE_WAIT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;
`else
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;
`endif

  // Legal WAIT_CYCLES values fit the 4-bit wait counter; an out-of-range
  // value shows up as this named block in the elaborated hierarchy.
  if (WAIT_CYCLES > 15) begin : g_wait_cycles_out_of_range
  end

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
  logic                    rw_q, rw_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    rdy_q, rdy_d;
  logic [31:0]             rd_data_q, rd_data_d;
`ifdef YUTORINA_SLAVE_WAIT_EN
  logic [3:0]              cnt_q, cnt_d;
`endif

  logic [31:0]             mem [0:(1<<DEPTH_LOG2)-1];
  logic [31:0]             mem_rd_q;
  logic                    req;
  logic                    mem_we;
  logic                    mem_re;

  assign req = ~cs_ & ~as_;

  // Next-state, request latching and acknowledge/read-data generation.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    rdy_d     = 1'b1;
    rd_data_d = '0;
`ifdef YUTORINA_SLAVE_WAIT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr;
          rw_d    = rw;
          wdata_d = wr_data;
`ifdef YUTORINA_SLAVE_WAIT_EN
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? ACK : WAIT;
`else
          state_d = ACK;
`endif
        end
      end
`ifdef YUTORINA_SLAVE_WAIT_EN
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          state_d = ACK;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
`endif
      ACK: begin
        state_d   = IDLE;
        rdy_d     = 1'b0;
        rd_data_d = rw_q ? mem_rd_q : '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port: the array is touched only on the edge that enters ACK.
  // The read is captured there and forwarded to rd_data on the following
  // edge, keeping both the array read and the output registered. A reset on
  // that same edge suppresses the write so an abandoned write never lands.
  always_comb begin
    mem_we = (state_d == ACK) && !rw_d && !rst;
    mem_re = (state_d == ACK) &&  rw_d;
  end

  // Array storage; intentionally never initialised or cleared.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_d] <= wdata_d;
    end
    if (mem_re) begin
      mem_rd_q <= mem[addr_d];
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      rdy_q     <= 1'b1;
      rd_data_q <= '0;
`ifdef YUTORINA_SLAVE_WAIT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      rdy_q     <= rdy_d;
      rd_data_q <= rd_data_d;
`ifdef YUTORINA_SLAVE_WAIT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign rdy_    = rdy_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_yutorina_bus_slave_mem.sv
// Directed bench for yutorina_bus_slave_mem. Four instances with different
// WAIT_CYCLES; expectations follow whether YUTORINA_SLAVE_WAIT_EN is defined.
module tb_yutorina_bus_slave_mem;

`ifdef YUTORINA_SLAVE_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  localparam int NI = 4;

  function automatic int unsigned wc(input int i);
    case (i)
      0:       return 2;
      1:       return 0;
      2:       return 3;
      default: return 5;
    endcase
  endfunction

  function automatic int unsigned lat(input int i);
    return WAIT_EN ? wc(i) : 0;
  endfunction

  logic        clk = 1'b0;
  logic        rst   [NI];
  logic        cs_n  [NI];
  logic        as_n  [NI];
  logic        rw    [NI];
  logic [10:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [31:0] rdata [NI];
  logic        rdy_n [NI];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    yutorina_bus_slave_mem #(
      .WAIT_CYCLES(wc(g)),
      .DEPTH_LOG2 (11)
    ) u_dut (
      .clk    (clk),
      .rst    (rst[g]),
      .cs_    (cs_n[g]),
      .as_    (as_n[g]),
      .rw     (rw[g]),
      .addr   (addr[g]),
      .wr_data(wdata[g]),
      .rd_data(rdata[g]),
      .rdy_   (rdy_n[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input int i, input string tag, input logic exp_rdy, input logic [31:0] exp_rd);
    chk({tag, "_rdy"}, 32'(rdy_n[i]), 32'(exp_rdy));
    chk({tag, "_rd"}, rdata[i], exp_rd);
  endtask

  // Full transaction: request held until the acknowledge cycle is seen.
  task automatic access(input int i, input logic r, input logic [10:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
    int unsigned l;
    l = lat(i);
    @(negedge clk);
    cs_n[i] = 1'b0; as_n[i] = 1'b0; rw[i] = r; addr[i] = a; wdata[i] = wd;
    @(posedge clk);
    for (int unsigned k = 0; k <= l; k++) begin
      @(negedge clk);
      chk_out(i, {tag, "_pre"}, 1'b1, 32'h0);
      @(posedge clk);
    end
    @(negedge clk);
    chk_out(i, {tag, "_ack"}, 1'b0, exp_rd);
    cs_n[i] = 1'b1; as_n[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_out(i, {tag, "_post"}, 1'b1, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned l;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; cs_n[i] = 1'b1; as_n[i] = 1'b1; rw[i] = 1'b1;
      addr[i] = '0; wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk_out(i, "reset", 1'b1, 32'h0);
      rst[i] = 1'b0;
    end

    // Instance 0 (WAIT_CYCLES=2): write then read back.
    access(0, 1'b0, 11'h010, 32'hDEADBEEF, 32'h0, "wr010");
    access(0, 1'b1, 11'h010, 32'h0, 32'hDEADBEEF, "rd010");

    // Instance 0: address/direction changed after acceptance are ignored.
    access(0, 1'b0, 11'h030, 32'hA5A50030, 32'h0, "wr030");
    access(0, 1'b0, 11'h031, 32'h5A5A0031, 32'h0, "wr031");
    l = lat(0);
    @(negedge clk);
    cs_n[0] = 1'b0; as_n[0] = 1'b0; rw[0] = 1'b1; addr[0] = 11'h030;
    @(posedge clk);
    for (int unsigned k = 0; k <= l; k++) begin
      @(negedge clk);
      if (k == 0) begin
        addr[0] = 11'h031; rw[0] = 1'b0; wdata[0] = 32'hFFFFFFFF;
      end
      chk_out(0, "chg_pre", 1'b1, 32'h0);
      @(posedge clk);
    end
    @(negedge clk);
    chk_out(0, "chg_ack", 1'b0, 32'hA5A50030);
    cs_n[0] = 1'b1; as_n[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_out(0, "chg_post", 1'b1, 32'h0);
    access(0, 1'b1, 11'h031, 32'h0, 32'h5A5A0031, "rd031");
    access(0, 1'b1, 11'h030, 32'h0, 32'hA5A50030, "rd030");

    // Instance 0: reset on the edge that would commit a write.
    access(0, 1'b0, 11'h040, 32'h11112222, 32'h0, "wr040");
    l = lat(0);
    @(negedge clk);
    cs_n[0] = 1'b0; as_n[0] = 1'b0; rw[0] = 1'b0; addr[0] = 11'h040; wdata[0] = 32'h33334444;
    if (l == 0) rst[0] = 1'b1;
    @(posedge clk);
    for (int unsigned k = 1; k <= l; k++) begin
      @(negedge clk);
      chk_out(0, "rstw_pre", 1'b1, 32'h0);
      if (k == l) rst[0] = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    chk_out(0, "rstw_after", 1'b1, 32'h0);
    rst[0] = 1'b0; cs_n[0] = 1'b1; as_n[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_out(0, "rstw_idle", 1'b1, 32'h0);
    access(0, 1'b1, 11'h040, 32'h0, 32'h11112222, "rd040");

    // Instance 1 (WAIT_CYCLES=0): back-to-back reads at the address extremes.
    access(1, 1'b0, 11'h000, 32'h0000AAAA, 32'h0, "wr000");
    access(1, 1'b0, 11'h7FF, 32'hFFFF0001, 32'h0, "wr7ff");
    @(negedge clk);
    cs_n[1] = 1'b0; as_n[1] = 1'b0; rw[1] = 1'b1; addr[1] = 11'h000;
    for (int p = 0; p < 4; p++) begin
      @(posedge clk);
      @(negedge clk);
      chk_out(1, "b2b_gap", 1'b1, 32'h0);
      addr[1] = (p % 2 == 0) ? 11'h7FF : 11'h000;
      @(posedge clk);
      @(negedge clk);
      chk_out(1, "b2b_ack", 1'b0, (p % 2 == 0) ? 32'h0000AAAA : 32'hFFFF0001);
    end
    cs_n[1] = 1'b1; as_n[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_out(1, "b2b_end", 1'b1, 32'h0);

    // Instance 2 (WAIT_CYCLES=3): chip select dropped one cycle into a write.
    access(2, 1'b0, 11'h020, 32'hCAFE0020, 32'h0, "wr020");
    @(negedge clk);
    cs_n[2] = 1'b0; as_n[2] = 1'b0; rw[2] = 1'b0; addr[2] = 11'h020; wdata[2] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    chk_out(2, "abort_n", 1'b1, 32'h0);
    cs_n[2] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk_out(2, "abort_k", (!WAIT_EN && k == 1) ? 1'b0 : 1'b1, 32'h0);
    end
    as_n[2] = 1'b1;
    access(2, 1'b1, 11'h020, 32'h0, WAIT_EN ? 32'hCAFE0020 : 32'h12345678, "rd020");

    // Instance 3 (WAIT_CYCLES=5): latency follows the build option.
    access(3, 1'b0, 11'h155, 32'h0F0F5555, 32'h0, "wr155");
    access(3, 1'b0, 11'h2AA, 32'h13572468, 32'h0, "wr2aa");
    access(3, 1'b1, 11'h2AA, 32'h0, 32'h13572468, "rd2aa");
    access(3, 1'b1, 11'h155, 32'h0, 32'h0F0F5555, "rd155");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
